// File: rtl/param_shift_reg.sv
// param_shift_reg: WIDTH-bit by DEPTH-stage shift register with hold, shift,
// rotate and parallel load. It also tracks how many stages hold valid data.
// Stage 0 is the serial input end and stage DEPTH-1 drives sout. pload and
// pout both pack stage i into bits [i*WIDTH +: WIDTH].
module param_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           sin,
  input  logic [DEPTH*WIDTH-1:0]     pload,
  output logic [WIDTH-1:0]           sout,
  output logic [DEPTH*WIDTH-1:0]     pout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  // The packed layout keeps stage i at [i] so it lines up with the pload/pout slicing.
  logic [DEPTH-1:0][WIDTH-1:0] stages;
  logic [CW-1:0]               validCount;

  // Stage register update: clr wins, then en gates the mode-selected operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (clr) begin
      stages <= '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: stages <= stages;
        MODE_SHIFT: begin
          stages[0] <= sin;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
        MODE_ROTATE: begin
          stages[0] <= stages[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
        MODE_LOAD: stages <= pload;
        default: stages <= stages;
      endcase
    end
  end

  // Valid-stage counter: a shift adds one stage up to DEPTH, a load fills every stage, and a rotate keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validCount <= '0;
    end else if (clr) begin
      validCount <= '0;
    end else if (en) begin
      case (mode)
        MODE_SHIFT: begin
          if (validCount != COUNT_MAX) begin
            validCount <= validCount + 1'b1;
          end
        end
        MODE_LOAD: validCount <= COUNT_MAX;
        default:   validCount <= validCount;
      endcase
    end
  end

  // All outputs come straight from state. full decodes only the count register.
  assign pout  = stages;
  assign sout  = stages[DEPTH-1];
  assign count = validCount;
  assign full  = (validCount == COUNT_MAX);

endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed table of vectors plus hand-written sequences for
// the async reset and the default-parameter delay line.
module tb_param_shift_reg;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  sin;
  logic [31:0] pload;
  logic [7:0]  sout;
  logic [31:0] pout;
  logic [2:0]  count;
  logic        full;

  logic        clrD;
  logic        enD;
  logic [1:0]  modeD;
  logic [0:0]  sinD;
  logic [2:0]  ploadD;
  logic [0:0]  soutD;
  logic [2:0]  poutD;
  logic [1:0]  countD;
  logic        fullD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        clr;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  sin;
    logic [31:0] pload;
    logic [31:0] expPout;
    logic [2:0]  expCount;
    logic        expFull;
  } vecT;

  vecT vecs[$];

  param_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .sin(sin),
    .pload(pload), .sout(sout), .pout(pout), .count(count), .full(full)
  );

  param_shift_reg dutDef (
    .clk(clk), .rst_n(rst_n), .clr(clrD), .en(enD), .mode(modeD), .sin(sinD),
    .pload(ploadD), .sout(soutD), .pout(poutD), .count(countD), .full(fullD)
  );

  // Free-running clock. Rising edges occur at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vecT mk(string n, logic c, logic e, logic [1:0] m, logic [7:0] s,
                             logic [31:0] pl, logic [31:0] ep, logic [2:0] ec, logic ef);
    vecT v;
    v.name = n; v.clr = c; v.en = e; v.mode = m; v.sin = s; v.pload = pl;
    v.expPout = ep; v.expCount = ec; v.expFull = ef;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    clr = v.clr; en = v.en; mode = v.mode; sin = v.sin; pload = v.pload;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVec(input vecT v);
    checkOutput({v.name, ".pout"},  pout,         v.expPout);
    checkOutput({v.name, ".sout"},  32'(sout),    32'(v.expPout[31:24]));
    checkOutput({v.name, ".count"}, 32'(count),   32'(v.expCount));
    checkOutput({v.name, ".full"},  32'(full),    32'(v.expFull));
  endtask

  task automatic stepDef(input logic s, input logic expSout, input logic [2:0] expPout,
                         input logic [1:0] expCount);
    enD = 1'b1; modeD = 2'b01; sinD = s;
    @(posedge clk);
    #1;
    checkOutput("def.sout",  32'(soutD),  32'(expSout));
    checkOutput("def.pout",  32'(poutD),  32'(expPout));
    checkOutput("def.count", 32'(countD), 32'(expCount));
  endtask

  initial begin
    vecT v;

    vecs.push_back(mk("shift1",   0, 1, 2'b01, 8'h11, 32'h0,        32'h00000011, 3'd1, 0));
    vecs.push_back(mk("shift2",   0, 1, 2'b01, 8'h22, 32'h0,        32'h00001122, 3'd2, 0));
    vecs.push_back(mk("shift3",   0, 1, 2'b01, 8'h33, 32'h0,        32'h00112233, 3'd3, 0));
    vecs.push_back(mk("shift4",   0, 1, 2'b01, 8'h44, 32'h0,        32'h11223344, 3'd4, 1));
    vecs.push_back(mk("shiftSat", 0, 1, 2'b01, 8'h55, 32'h0,        32'h22334455, 3'd4, 1));
    vecs.push_back(mk("clr",      1, 0, 2'b01, 8'h66, 32'h0,        32'h00000000, 3'd0, 0));
    vecs.push_back(mk("load",     0, 1, 2'b11, 8'h00, 32'h44332211, 32'h44332211, 3'd4, 1));
    vecs.push_back(mk("rotate",   0, 1, 2'b10, 8'h00, 32'h0,        32'h33221144, 3'd4, 1));
    vecs.push_back(mk("hold",     0, 1, 2'b00, 8'h99, 32'hffffffff, 32'h33221144, 3'd4, 1));
    vecs.push_back(mk("disLoad",  0, 0, 2'b11, 8'h99, 32'hffffffff, 32'h33221144, 3'd4, 1));
    vecs.push_back(mk("clrWins",  1, 1, 2'b11, 8'h99, 32'hffffffff, 32'h00000000, 3'd0, 0));
    vecs.push_back(mk("shiftA",   0, 1, 2'b01, 8'haa, 32'h0,        32'h000000aa, 3'd1, 0));
    vecs.push_back(mk("shiftB",   0, 1, 2'b01, 8'hbb, 32'h0,        32'h0000aabb, 3'd2, 0));
    vecs.push_back(mk("dis1",     0, 0, 2'b01, 8'hcc, 32'h0,        32'h0000aabb, 3'd2, 0));
    vecs.push_back(mk("dis2",     0, 0, 2'b01, 8'hcc, 32'h0,        32'h0000aabb, 3'd2, 0));
    vecs.push_back(mk("dis3",     0, 0, 2'b01, 8'hcc, 32'h0,        32'h0000aabb, 3'd2, 0));
    vecs.push_back(mk("shiftC",   0, 1, 2'b01, 8'hcc, 32'h0,        32'h00aabbcc, 3'd3, 0));
    vecs.push_back(mk("rotPart",  0, 1, 2'b10, 8'h00, 32'h0,        32'haabbcc00, 3'd3, 0));
    vecs.push_back(mk("shiftD",   0, 1, 2'b01, 8'hdd, 32'h0,        32'hbbcc00dd, 3'd4, 1));
    vecs.push_back(mk("load2",    0, 1, 2'b11, 8'h00, 32'h01020304, 32'h01020304, 3'd4, 1));

    rst_n = 1'b0;
    clr = 1'b0; en = 1'b0; mode = 2'b00; sin = 8'h00; pload = 32'h0;
    clrD = 1'b0; enD = 1'b0; modeD = 2'b00; sinD = 1'b0; ploadD = 3'b0;
    #1;
    checkOutput("reset.pout",  pout,        32'h0);
    checkOutput("reset.count", 32'(count),  32'h0);
    checkOutput("reset.full",  32'(full),   32'h0);
    checkOutput("reset.def",   32'(poutD),  32'h0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVec(vecs[i]);
    end

    // Asynchronous reset in mid-cycle while full. Shifting must resume on the next edge.
    rst_n = 1'b0;
    #2;
    checkOutput("asyncRst.pout",  pout,       32'h0);
    checkOutput("asyncRst.count", 32'(count), 32'h0);
    checkOutput("asyncRst.full",  32'(full),  32'h0);
    checkOutput("asyncRst.sout",  32'(sout),  32'h0);
    #1 rst_n = 1'b1;
    v = mk("resume", 0, 1, 2'b01, 8'h77, 32'h0, 32'h00000077, 3'd1, 0);
    applyStimulus(v);
    checkVec(v);

    // Default parameters: 3-stage, 1-bit delay line.
    en = 1'b0;
    stepDef(1'b1, 1'b0, 3'b001, 2'd1);
    stepDef(1'b0, 1'b0, 3'b010, 2'd2);
    stepDef(1'b1, 1'b1, 3'b101, 2'd3);
    checkOutput("def.full", 32'(fullD), 32'h1);
    stepDef(1'b0, 1'b0, 3'b010, 2'd3);
    stepDef(1'b0, 1'b1, 3'b100, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
